// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: state encodings and default counter width for the run controller, shared with the system top
package run_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    ST_HALT = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_BRK  = 3'd3,
    ST_EXC  = 3'd4
  } rc_state_e;
endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: CPU run/step/halt controller with breakpoint, exception capture and retired-instruction counter
// Ports: SYS_clk/SYS_reset (sync, active-high); RC_cmd_* one-cycle command pulses; RC_bp_en/RC_bp_addr breakpoint;
// RC_pc/RC_exception from the CPU; RC_cpu_en commit enable; RC_state, RC_epc, RC_step_done, RC_icount status.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             RC_cmd_run,
  input  logic             RC_cmd_step,
  input  logic             RC_cmd_halt,
  input  logic             RC_cmd_clr,
  input  logic             RC_bp_en,
  input  logic [7:0]       RC_bp_addr,
  input  logic [7:0]       RC_pc,
  input  logic             RC_exception,
  output logic             RC_cpu_en,
  output logic [2:0]       RC_state,
  output logic [7:0]       RC_epc,
  output logic             RC_step_done,
  output logic [CNT_W-1:0] RC_icount
);
  rc_state_e        state_q, state_d;
  logic             skip_q, skip_d;
  logic [7:0]       epc_q, epc_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             step_done_q, step_done_d;
  logic             bp_hit, cpu_en, fault, clr_eff, step_eff, run_eff, resume;
  always_comb begin
    bp_hit   = RC_bp_en & (RC_pc == RC_bp_addr) & ~skip_q;
    cpu_en   = (state_q == ST_RUN & ~bp_hit) | state_q == ST_STEP;
    fault    = cpu_en & RC_exception;
    clr_eff  = RC_cmd_clr & ~RC_cmd_halt;
    step_eff = RC_cmd_step & ~RC_cmd_halt & ~RC_cmd_clr;
    run_eff  = RC_cmd_run & ~RC_cmd_halt & ~RC_cmd_clr & ~RC_cmd_step;
    state_d  = state_q;
    resume   = 1'b0;
    case (state_q)
      ST_HALT: state_d = step_eff ? ST_STEP : run_eff ? ST_RUN : ST_HALT;
      ST_RUN:  state_d = fault ? ST_EXC : RC_cmd_halt ? ST_HALT : bp_hit ? ST_BRK : ST_RUN;
      ST_STEP: state_d = fault ? ST_EXC : ST_HALT;
      ST_BRK: begin
        state_d = RC_cmd_halt ? ST_HALT : step_eff ? ST_STEP : run_eff ? ST_RUN : ST_BRK;
        resume  = step_eff | run_eff;
      end
      ST_EXC:  state_d = (RC_cmd_halt | RC_cmd_clr) ? ST_HALT : ST_EXC;
      default: state_d = ST_HALT;
    endcase
    // Leaving a breakpoint arms skip so the parked instruction can commit once.
    skip_d      = (state_d == ST_HALT | state_d == ST_EXC) ? 1'b0 : resume ? 1'b1 : cpu_en ? 1'b0 : skip_q;
    icount_d    = clr_eff ? '0 : (cpu_en & ~RC_exception) ? icount_q + CNT_W'(1) : icount_q;
    epc_d       = fault ? RC_pc : epc_q;
    step_done_d = state_q == ST_STEP & ~fault & ~RC_cmd_halt;
  end
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q     <= ST_HALT;
      skip_q      <= 1'b0;
      epc_q       <= '0;
      icount_q    <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      epc_q       <= epc_d;
      icount_q    <= icount_d;
      step_done_q <= step_done_d;
    end
  end
  assign RC_cpu_en    = cpu_en;
  assign RC_state     = state_q;
  assign RC_epc       = epc_q;
  assign RC_step_done = step_done_q;
  assign RC_icount    = icount_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scenario tasks plus randomized run against a behavioural run-controller model
module tb_run_ctrl;
  localparam int H = 0, R = 1, S = 2, B = 3, E = 4;
  logic clk = 0, rst = 0, run = 0, step = 0, halt = 0, clr = 0, bp_en = 0, exc = 0;
  logic [7:0] bp_addr = 0, pc = 0;
  logic cpu_en, cpu_en4, done, done4;
  logic [2:0] st, st4;
  logic [7:0] epc, epc4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int vec = 0, bad = 0;
  bit auto_pc = 0;
  int m_state = H;
  bit m_skip = 0, m_done = 0;
  logic [7:0] m_epc = 0;
  int unsigned m_cnt = 0;

  always #5 clk = ~clk;

  run_ctrl dut (
    .SYS_clk(clk), .SYS_reset(rst), .RC_cmd_run(run), .RC_cmd_step(step), .RC_cmd_halt(halt),
    .RC_cmd_clr(clr), .RC_bp_en(bp_en), .RC_bp_addr(bp_addr), .RC_pc(pc), .RC_exception(exc),
    .RC_cpu_en(cpu_en), .RC_state(st), .RC_epc(epc), .RC_step_done(done), .RC_icount(cnt)
  );

  run_ctrl #(.CNT_W(4)) dut4 (
    .SYS_clk(clk), .SYS_reset(rst), .RC_cmd_run(run), .RC_cmd_step(step), .RC_cmd_halt(halt),
    .RC_cmd_clr(clr), .RC_bp_en(bp_en), .RC_bp_addr(bp_addr), .RC_pc(pc), .RC_exception(exc),
    .RC_cpu_en(cpu_en4), .RC_state(st4), .RC_epc(epc4), .RC_step_done(done4), .RC_icount(cnt4)
  );

  function automatic bit m_en();
    bit hit = bp_en && pc == bp_addr && !m_skip;
    return (m_state == R && !hit) || m_state == S;
  endfunction

  // One clock edge: the model consumes the inputs seen at the edge, then the emulated CPU advances its PC.
  task automatic tick();
    bit en = m_en();
    bit hit = bp_en && pc == bp_addr && !m_skip;
    bit fault = en && exc;
    bit commit = en && !exc && !rst;
    int ns = m_state;
    bit sk = m_skip;
    @(posedge clk);
    if (rst) begin
      m_state = H; m_skip = 0; m_epc = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = m_state == S && !fault && !halt;
      if (clr && !halt) m_cnt = 0;
      else if (en && !exc) m_cnt++;
      if (fault) m_epc = pc;
      if (en) sk = 0;
      if (fault) ns = E;
      else if (m_state == H) ns = (halt || clr) ? H : step ? S : run ? R : H;
      else if (m_state == R) ns = halt ? H : hit ? B : R;
      else if (m_state == S) ns = H;
      else if (m_state == B) begin
        if (halt) ns = H;
        else if (!clr && (step || run)) begin ns = step ? S : R; sk = 1; end
      end else if (m_state == E) ns = (halt || clr) ? H : E;
      if (ns == H || ns == E) sk = 0;
      m_state = ns;
      m_skip = sk;
    end
    #1;
    if (auto_pc && commit) pc = pc + 8'd4;
    #1;
  endtask

  task automatic cmd(input bit r, input bit s, input bit h, input bit c);
    run = r; step = s; halt = h; clr = c;
    tick();
    run = 0; step = 0; halt = 0; clr = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0; #1;
    vec++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    vec++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
    vec++; if (epc !== 8'h00) begin bad++; $display("FAIL reset_epc got=%h exp=00", epc); end
    vec++; if (cnt !== 16'd0 || cnt4 !== 4'd0) begin bad++; $display("FAIL reset_icount got=%0d/%0d exp=0", cnt, cnt4); end
    vec++; if (done !== 1'b0) begin bad++; $display("FAIL reset_step_done got=%b exp=0", done); end
  endtask

  task automatic test_step();
    pc = 8'h40;
    cmd(0, 1, 0, 0);
    vec++; if (st !== 3'd2 || cpu_en !== 1'b1) begin bad++; $display("FAIL step_enter got st=%0d en=%b exp st=2 en=1", st, cpu_en); end
    tick();
    vec++; if (st !== 3'd0 || cpu_en !== 1'b0) begin bad++; $display("FAIL step_exit got st=%0d en=%b exp st=0 en=0", st, cpu_en); end
    vec++; if (done !== 1'b1) begin bad++; $display("FAIL step_done_pulse got=%b exp=1", done); end
    vec++; if (cnt !== 16'd1 || cnt4 !== 4'd1) begin bad++; $display("FAIL step_icount got=%0d/%0d exp=1", cnt, cnt4); end
    tick();
    vec++; if (done !== 1'b0) begin bad++; $display("FAIL step_done_single got=%b exp=0", done); end
  endtask

  task automatic test_breakpoint();
    int n = 0;
    cmd(0, 0, 0, 1);
    pc = 8'h00; bp_en = 1; bp_addr = 8'h0C; auto_pc = 1;
    cmd(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (cpu_en) n++;
      if (st == 3'd3) break;
      tick();
    end
    vec++; if (n != 3) begin bad++; $display("FAIL bp_en_cycles got=%0d exp=3", n); end
    vec++; if (st !== 3'd3 || pc !== 8'h0C) begin bad++; $display("FAIL bp_stop got st=%0d pc=%h exp st=3 pc=0c", st, pc); end
    vec++; if (cnt !== 16'd3 || cpu_en !== 1'b0) begin bad++; $display("FAIL bp_icount got cnt=%0d en=%b exp cnt=3 en=0", cnt, cpu_en); end
  endtask

  task automatic test_skip();
    int n = 0;
    cmd(1, 0, 0, 0);
    vec++; if (st !== 3'd1 || cpu_en !== 1'b1) begin bad++; $display("FAIL skip_resume got st=%0d en=%b exp st=1 en=1", st, cpu_en); end
    tick();
    vec++; if (st !== 3'd1 || pc !== 8'h10) begin bad++; $display("FAIL skip_past got st=%0d pc=%h exp st=1 pc=10", st, pc); end
    for (int i = 0; i < 100; i++) begin
      if (st == 3'd3) break;
      tick(); n++;
    end
    vec++; if (n != 64 || pc !== 8'h0C) begin bad++; $display("FAIL skip_rehit got ticks=%0d pc=%h exp ticks=64 pc=0c", n, pc); end
    vec++; if (cnt !== 16'd67 || cnt4 !== 4'd3) begin bad++; $display("FAIL skip_icount got=%0d/%0d exp=67/3", cnt, cnt4); end
    cmd(0, 0, 1, 0);
    vec++; if (st !== 3'd0) begin bad++; $display("FAIL brk_halt got=%0d exp=0", st); end
    auto_pc = 0; bp_en = 0;
  endtask

  task automatic test_exception();
    pc = 8'h20;
    cmd(1, 0, 0, 0);
    exc = 1; tick(); exc = 0; #1;
    vec++; if (st !== 3'd4 || epc !== 8'h20 || cpu_en !== 1'b0) begin bad++; $display("FAIL exc_enter got st=%0d epc=%h en=%b exp 4/20/0", st, epc, cpu_en); end
    vec++; if (cnt !== 16'd67) begin bad++; $display("FAIL exc_not_counted got=%0d exp=67", cnt); end
    cmd(1, 0, 0, 0);
    cmd(0, 1, 0, 0);
    vec++; if (st !== 3'd4 || cnt !== 16'd67) begin bad++; $display("FAIL exc_ignore got st=%0d cnt=%0d exp 4/67", st, cnt); end
    cmd(0, 0, 0, 1);
    vec++; if (st !== 3'd0 || cnt !== 16'd0 || epc !== 8'h20) begin bad++; $display("FAIL exc_clr got st=%0d cnt=%0d epc=%h exp 0/0/20", st, cnt, epc); end
    pc = 8'h33; exc = 1; tick(); exc = 0; #1;
    vec++; if (st !== 3'd0 || epc !== 8'h20) begin bad++; $display("FAIL exc_idle got st=%0d epc=%h exp 0/20", st, epc); end
    pc = 8'h44;
    cmd(1, 0, 0, 0);
    tick();
    exc = 1; tick(); exc = 0; #1;
    cmd(0, 0, 1, 0);
    vec++; if (st !== 3'd0 || cnt !== 16'd1 || epc !== 8'h44) begin bad++; $display("FAIL exc_halt got st=%0d cnt=%0d epc=%h exp 0/1/44", st, cnt, epc); end
  endtask

  task automatic test_wrap();
    cmd(0, 0, 0, 1);
    pc = 8'h00; auto_pc = 1;
    cmd(1, 0, 0, 0);
    repeat (16) tick();
    halt = 1; tick(); halt = 0; #1;
    vec++; if (st !== 3'd0 || cnt !== 16'd17 || cnt4 !== 4'd1) begin bad++; $display("FAIL wrap got st=%0d cnt=%0d cnt4=%0d exp 0/17/1", st, cnt, cnt4); end
    cmd(1, 0, 0, 0);
    tick(); tick();
    clr = 1; tick(); clr = 0; #1;
    vec++; if (st !== 3'd1 || cnt !== 16'd0 || cnt4 !== 4'd0) begin bad++; $display("FAIL clr_vs_inc got st=%0d cnt=%0d cnt4=%0d exp 1/0/0", st, cnt, cnt4); end
    cmd(0, 0, 1, 0);
    vec++; if (st !== 3'd0 || cnt !== 16'd1) begin bad++; $display("FAIL run_halt_commit got st=%0d cnt=%0d exp 0/1", st, cnt); end
    auto_pc = 0;
  endtask

  task automatic test_step_halt();
    cmd(0, 1, 0, 0);
    halt = 1; tick(); halt = 0; #1;
    vec++; if (st !== 3'd0 || done !== 1'b0 || cnt !== 16'd2) begin bad++; $display("FAIL step_halt got st=%0d done=%b cnt=%0d exp 0/0/2", st, done, cnt); end
  endtask

  task automatic test_back_to_back();
    cmd(1, 0, 1, 0);
    vec++; if (st !== 3'd0 || cpu_en !== 1'b0) begin bad++; $display("FAIL halt_run_same got st=%0d en=%b exp 0/0", st, cpu_en); end
    pc = 8'h50;
    cmd(1, 0, 0, 0);
    tick();
    rst = 1; tick(); rst = 0; #1;
    vec++; if (st !== 3'd0 || cpu_en !== 1'b0 || cnt !== 16'd0 || epc !== 8'h00 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid_run got st=%0d en=%b cnt=%0d epc=%h done=%b exp all 0", st, cpu_en, cnt, epc, done);
    end
    cmd(0, 1, 0, 0);
    rst = 1; tick(); rst = 0; #1;
    vec++; if (cpu_en !== 1'b0 || cnt !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL reset_mid_step got en=%b cnt=%0d done=%b exp 0/0/0", cpu_en, cnt, done); end
  endtask

  task automatic test_random();
    auto_pc = 1;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 60) == 0;
      run = ($urandom % 7) == 0;
      step = ($urandom % 9) == 0;
      halt = ($urandom % 12) == 0;
      clr = ($urandom % 20) == 0;
      exc = ($urandom % 8) == 0;
      bp_en = ($urandom % 3) != 0;
      if (($urandom % 16) == 0) bp_addr = 8'($urandom % 16) << 2;
      if (($urandom % 24) == 0) pc = 8'($urandom % 20) << 2;
      #1;
      vec++; if (cpu_en !== m_en() || cpu_en4 !== m_en()) begin bad++; $display("FAIL rnd_cpu_en cyc=%0d got=%b/%b exp=%b", i, cpu_en, cpu_en4, m_en()); end
      vec++; if (st !== 3'(m_state) || st4 !== 3'(m_state)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d/%0d exp=%0d", i, st, st4, m_state); end
      vec++; if (epc !== m_epc || epc4 !== m_epc) begin bad++; $display("FAIL rnd_epc cyc=%0d got=%h/%h exp=%h", i, epc, epc4, m_epc); end
      vec++; if (cnt !== m_cnt[15:0] || cnt4 !== m_cnt[3:0]) begin bad++; $display("FAIL rnd_icount cyc=%0d got=%0d/%0d exp=%0d/%0d", i, cnt, cnt4, m_cnt[15:0], m_cnt[3:0]); end
      vec++; if (done !== m_done || done4 !== m_done) begin bad++; $display("FAIL rnd_step_done cyc=%0d got=%b/%b exp=%b", i, done, done4, m_done); end
      tick();
    end
    rst = 0; run = 0; step = 0; halt = 0; clr = 0; exc = 0; auto_pc = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_step();
    test_breakpoint();
    test_skip();
    test_exception();
    test_wrap();
    test_step_halt();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vec);
    $fatal(1, "timeout");
  end
endmodule
